// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//   Shares one single-port memory between the core's data port (D) and its
//   instruction-fetch port (I). Data has fixed priority over fetch. A starvation
//   counter forces a fetch grant after STARVE_LIMIT consecutive data grants made
//   while fetch was waiting.
//
// Handshake (all three ports): the requester raises req with stable
//   addr/we/wdata and holds them until its one-cycle ack pulse. rdata is valid
//   while ack is high and holds its value afterwards. The arbiter presents
//   m_req/m_we/m_addr/m_wdata stable until the memory pulses m_ack.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   d_req/d_we/d_addr/d_wdata  data request in
//   d_rdata/d_ack              data response out
//   i_req/i_addr               fetch request in (always a read)
//   i_rdata/i_ack              fetch response out
//   m_req/m_we/m_addr/m_wdata  memory request out
//   m_rdata/m_ack              memory response in
//   bus_err                    timeout flag, pulses with ack (ARB_TIMEOUT_EN only)
//   dbg_state_o                current FSM state (IDLE=0, BUSY=1, DONE=2)
//
// Build option
//   ARB_TIMEOUT_EN : abandons a memory access after TIMEOUT BUSY cycles without
//                    m_ack, acks the owner with rdata=0 and raises bus_err.
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 255
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_ack,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic [DW-1:0] i_rdata,
  output logic          i_ack,
  output logic          m_req,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata,
  input  logic          m_ack,
`ifdef ARB_TIMEOUT_EN
  output logic          bus_err,
`endif
  output logic [1:0]    dbg_state_o
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  logic [1:0]    state_q, state_d;
  logic          owner_q, owner_d;      // 1 = fetch owns the memory
  logic [3:0]    starve_q, starve_d;
  logic          m_req_q, m_req_d;
  logic          m_we_q, m_we_d;
  logic [AW-1:0] m_addr_q, m_addr_d;
  logic [DW-1:0] m_wdata_q, m_wdata_d;
  logic [DW-1:0] d_rdata_q, d_rdata_d;
  logic [DW-1:0] i_rdata_q, i_rdata_d;
  logic          d_ack_q, d_ack_d;
  logic          i_ack_q, i_ack_d;

  logic          i_wins;
  logic          finish;
  logic          fin_load;
  logic [DW-1:0] fin_rdata;

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] TO_MAX = 8'(TIMEOUT);
  logic [7:0] wait_q, wait_d;
  logic       bus_err_q, bus_err_d;
`else
  // TIMEOUT only has a meaning when the timeout logic is compiled in.
  logic unused_timeout;
  assign unused_timeout = |TIMEOUT;
`endif

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    starve_d  = starve_q;
    m_req_d   = m_req_q;
    m_we_d    = m_we_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    d_rdata_d = d_rdata_q;
    i_rdata_d = i_rdata_q;
    d_ack_d   = 1'b0;
    i_ack_d   = 1'b0;
    i_wins    = 1'b0;
    finish    = 1'b0;
    fin_load  = !m_we_q;               // only reads update rdata
    fin_rdata = m_rdata;
`ifdef ARB_TIMEOUT_EN
    wait_d    = wait_q;
    bus_err_d = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (d_req || i_req) begin
          i_wins = i_req && (!d_req || (starve_q == STARVE_MAX));
          if (i_wins) begin
            owner_d   = 1'b1;
            m_we_d    = 1'b0;
            m_addr_d  = i_addr;
            m_wdata_d = '0;
            starve_d  = '0;
          end else begin
            owner_d   = 1'b0;
            m_we_d    = d_we;
            m_addr_d  = d_addr;
            m_wdata_d = d_wdata;
            // Count only data grants that made a waiting fetch lose.
            if (i_req) begin
              starve_d = (starve_q == STARVE_MAX) ? starve_q : starve_q + 4'd1;
            end else begin
              starve_d = '0;
            end
          end
          m_req_d = 1'b1;
          state_d = BUSY;
`ifdef ARB_TIMEOUT_EN
          wait_d  = '0;
`endif
        end
      end
      BUSY: begin
        // m_ack has priority over a timeout landing in the same cycle.
        if (m_ack) begin
          finish = 1'b1;
        end
`ifdef ARB_TIMEOUT_EN
        else if ((wait_q + 8'd1) == TO_MAX) begin
          finish    = 1'b1;
          fin_load  = 1'b1;
          fin_rdata = '0;
          bus_err_d = 1'b1;
        end else begin
          wait_d = wait_q + 8'd1;
        end
`endif
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (finish) begin
      m_req_d = 1'b0;
      state_d = DONE;
      if (owner_q) begin
        i_ack_d = 1'b1;
        if (fin_load) i_rdata_d = fin_rdata;
      end else begin
        d_ack_d = 1'b1;
        if (fin_load) d_rdata_d = fin_rdata;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      owner_q   <= 1'b0;
      starve_q  <= '0;
      m_req_q   <= 1'b0;
      m_we_q    <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      d_rdata_q <= '0;
      i_rdata_q <= '0;
      d_ack_q   <= 1'b0;
      i_ack_q   <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      wait_q    <= '0;
      bus_err_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      starve_q  <= starve_d;
      m_req_q   <= m_req_d;
      m_we_q    <= m_we_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      d_rdata_q <= d_rdata_d;
      i_rdata_q <= i_rdata_d;
      d_ack_q   <= d_ack_d;
      i_ack_q   <= i_ack_d;
`ifdef ARB_TIMEOUT_EN
      wait_q    <= wait_d;
      bus_err_q <= bus_err_d;
`endif
    end
  end

  assign m_req       = m_req_q;
  assign m_we        = m_we_q;
  assign m_addr      = m_addr_q;
  assign m_wdata     = m_wdata_q;
  assign d_rdata     = d_rdata_q;
  assign d_ack       = d_ack_q;
  assign i_rdata     = i_rdata_q;
  assign i_ack       = i_ack_q;
  assign dbg_state_o = state_q;
`ifdef ARB_TIMEOUT_EN
  assign bus_err     = bus_err_q;
`endif

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-port memory between the core's data port (requester D) and instruction-fetch port (requester I).
- Each requester runs a req/ack handshake. The arbiter picks one request, drives the shared memory port, waits for the memory's ack (variable latency), then returns read data and ack to the winner.
- Data has fixed priority over instruction, with a starvation limit that guarantees fetch progress.
- Sits between the core's i_*/d_* buses and the RAM; the core stalls while a request is pending.

Parameters:
- AW, 32, address width
- DW, 32, data width
- STARVE_LIMIT, 4, consecutive D grants allowed while I is waiting before I is forced to win (1..15)
- TIMEOUT, 255, memory-ack wait limit in cycles; used only with ARB_TIMEOUT_EN (1..255)

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- d_req  in  1  data request, held until d_ack
- d_we  in  1  1 = write, 0 = read
- d_addr  in  AW  data address
- d_wdata  in  DW  data write data
- d_rdata  out  DW  data read data, valid with d_ack
- d_ack  out  1  one-cycle completion pulse to D
- i_req  in  1  fetch request, held until i_ack
- i_addr  in  AW  fetch address
- i_rdata  out  DW  fetch data, valid with i_ack
- i_ack  out  1  one-cycle completion pulse to I
- m_req  out  1  memory request, held until m_ack
- m_we  out  1  memory write enable
- m_addr  out  AW  memory address
- m_wdata  out  DW  memory write data
- m_rdata  in  DW  memory read data, valid with m_ack
- m_ack  in  1  memory completion, one-cycle pulse

Behaviour:
- Reset is asynchronous on rst_n low. All outputs go to 0, state goes to IDLE, and starve_cnt goes to 0.
- All outputs are registered.
- The FSM has three states: IDLE, BUSY and DONE.

IDLE:
- If either request is high, choose a winner and capture its addr, wdata and we into the m_* registers. D's wdata is used; I always has we=0 and wdata=0.
- Set m_req=1, record the owner (D or I), and go to BUSY.
- Winner rule: I wins if i_req and (!d_req or starve_cnt == STARVE_LIMIT). Otherwise D wins.
- starve_cnt changes only at grant time:
  - D granted while i_req=1: increment, saturating at STARVE_LIMIT.
  - Any other grant: clear to 0.
- With no request, stay in IDLE.

BUSY:
- Hold the m_* outputs stable.
- On m_ack, set m_req=0 and latch m_rdata into the owner's rdata register. The rdata register is written only for reads; on writes it keeps its old value.
- In the same edge, set the owner's ack=1 and go to DONE.

DONE:
- Clear the ack. Return to IDLE.

Latency and rates:
- Request seen at edge 0 gives m_req high after edge 0.
- m_ack sampled at edge k gives ack high for the cycle after edge k.
- Minimum request-to-ack is 2 cycles when the memory acks in the first m_req cycle.
- Peak throughput is one transaction per 3 cycles.

Handshake rules:
- A requester must keep req, addr and data stable until its ack.
- A requester must drop req in the cycle after ack, or present a new request. A new request is evaluated in IDLE, so back-to-back requests are legal.
- The non-granted requester keeps waiting and is not acked.

Boundary conditions:
- m_ack in IDLE or DONE is ignored.
- Simultaneous d_req and i_req resolve per the winner rule.
- A requester that drops req while pending is protocol-illegal; the transaction still completes and its ack is still issued.
- rst_n asserted mid-transaction aborts immediately: m_req drops and no ack is issued.
- rdata holds its last value between acks.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- With the macro defined:
  - Adds output port bus_err (1 bit, reset 0).
  - An 8-bit wait counter clears on entry to BUSY and increments each BUSY cycle without m_ack.
  - When the counter reaches TIMEOUT: m_req=0, the owner's ack=1, bus_err=1, the owner's rdata=0, and go to DONE.
  - bus_err pulses with the ack. A late m_ack after timeout is ignored.
  - m_ack and timeout in the same cycle: m_ack wins, bus_err=0.
- Without the macro: no bus_err port, no counter, and BUSY waits for m_ack indefinitely.

Test Plan:
1. Reset then single read: i_req with i_addr=0x100, memory acks 1 cycle after m_req with 0xDEADBEEF -> m_addr=0x100, m_we=0; i_ack pulses 1 cycle with i_rdata=0xDEADBEEF at request+2 cycles; m_req=0 after.
2. Write: d_req, d_we=1, d_addr=0x2000, d_wdata=0x12345678, memory latency 3 -> m_we=1 and m_wdata=0x12345678 held 3 cycles; d_ack pulses; d_rdata unchanged.
3. Contention: d_req and i_req both high continuously, STARVE_LIMIT=4 -> grant order D,D,D,D,I,D,D,D,D,I...; i_ack every 5th transaction.
4. Reset mid-BUSY: assert rst_n=0 two cycles into a 5-cycle memory wait -> m_req, acks and rdata go to 0 immediately; after release, a stale m_ack is ignored with no ack issued.
5. Back-to-back D: d_req re-presented with a new address the cycle after d_ack, 10 transactions -> each issued in order at 3-cycle spacing with zero-latency memory; no duplicate acks.
6. ARB_TIMEOUT_EN with TIMEOUT=8, memory never acks -> after 8 BUSY cycles m_req=0, d_ack=1, bus_err=1, d_rdata=0; a next request with normal ack completes with bus_err=0.
